// File: rtl/key_sw_input_io_if.sv
// CPU I/O bus between the processor read/write path and the key/switch peripheral.
interface key_sw_input_io_if;
    logic        io_sel;
    logic [7:0]  addr;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output io_sel,
        output addr,
        output memwrite,
        output writedata,
        input  readdata
    );

    modport slave (
        input  io_sel,
        input  addr,
        input  memwrite,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/key_sw_input_io.sv
// Key/switch input peripheral: 2-flop sync, per-key debounce, W1C press capture, CPU read mux.
// Optional KEY_SW_IRQ_EN adds an interrupt mask register at addr[7] and a registered irq output.
module key_sw_input_io #(
    parameter int unsigned NKEY            = 4,
    parameter int unsigned NSW             = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NKEY-1:0]     key_raw,
    input  logic [NSW-1:0]      sw_raw,
    key_sw_input_io_if.slave    bus,
`ifdef KEY_SW_IRQ_EN
    output logic                irq,
`endif
    output logic [NKEY-1:0]     key_level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Key sync flops hold the raw active-low level, so reset to 1 means "released".
    logic [NKEY-1:0] key_s1;
    logic [NKEY-1:0] key_s2;
    logic [NSW-1:0]  sw_s1;
    logic [NSW-1:0]  sw_sync;
    logic [NKEY-1:0] key_sync;
    logic [CW-1:0]   cnt     [NKEY];
    logic [CW-1:0]   cnt_nxt [NKEY];
    logic [NKEY-1:0] level_nxt;
    logic [NKEY-1:0] rise;
    logic [NKEY-1:0] clr;
    logic [NKEY-1:0] edge_cap;
    logic [NKEY-1:0] edge_nxt;
`ifdef KEY_SW_IRQ_EN
    logic [NKEY-1:0] mask;
    logic            mask_we;
`endif
    logic            unused_bits;

    assign key_sync = ~key_s2;

    // Debounce: flip the stable level once the synced input has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        level_nxt = key_level;
        for (int i = 0; i < int'(NKEY); i++) begin
            cnt_nxt[i] = '0;
            if (key_sync[i] != key_level[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_nxt[i] = ~key_level[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press capture: a new press wins over a same-cycle W1C clear of that bit.
    always_comb begin
        rise     = level_nxt & ~key_level;
        clr      = '0;
        if (bus.io_sel && bus.addr[6] && bus.memwrite) begin
            clr = bus.writedata[NKEY-1:0];
        end
        edge_nxt = (edge_cap & ~clr) | rise;
    end

`ifdef KEY_SW_IRQ_EN
    assign mask_we = bus.io_sel && bus.addr[7] && bus.memwrite;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_s1    <= '1;
            key_s2    <= '1;
            sw_s1     <= '0;
            sw_sync   <= '0;
            key_level <= '0;
            edge_cap  <= '0;
            for (int i = 0; i < int'(NKEY); i++) begin
                cnt[i] <= '0;
            end
`ifdef KEY_SW_IRQ_EN
            mask      <= '0;
            irq       <= 1'b0;
`endif
        end else begin
            key_s1    <= key_raw;
            key_s2    <= key_s1;
            sw_s1     <= sw_raw;
            sw_sync   <= sw_s1;
            key_level <= level_nxt;
            edge_cap  <= edge_nxt;
            for (int i = 0; i < int'(NKEY); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
`ifdef KEY_SW_IRQ_EN
            if (mask_we) begin
                mask <= bus.writedata[NKEY-1:0];
            end
            irq       <= |(edge_cap & mask);
`endif
        end
    end

    // Read mux: one-hot address bits, lowest bit wins.
    always_comb begin
        bus.readdata = '0;
        if (bus.io_sel) begin
            if (bus.addr[4]) begin
                bus.readdata = 32'(key_level);
            end else if (bus.addr[5]) begin
                bus.readdata = 32'(sw_sync);
            end else if (bus.addr[6]) begin
                bus.readdata = 32'(edge_cap);
`ifdef KEY_SW_IRQ_EN
            end else if (bus.addr[7]) begin
                bus.readdata = 32'(mask);
`endif
            end
        end
    end

    assign unused_bits = ^{bus.addr[3:0], bus.addr[7], bus.writedata};

endmodule
